// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, registered in_ready, flush-to-bubble and NOP on bubbles.
// Optional: define IF_ID_BUBBLE_CNT_EN to add a saturating bubble_count output.
module if_id_skid_reg #(
  parameter int unsigned              PC_W     = 64,
  parameter int unsigned              INST_W   = 32,
  parameter logic [INST_W-1:0]        NOP_INST = INST_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_count
`endif
);

  // Buffer state is the pair {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  logic              main_vld_q, main_vld_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic              skid_vld_q, skid_vld_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, consume;
  state_e            state;

  assign state   = state_e'({main_vld_q, skid_vld_q});
  assign accept  = in_valid & in_ready_q;
  assign consume = main_vld_q & ~stall;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    main_vld_d  = main_vld_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_vld_d  = skid_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_vld_d  = 1'b1;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
          end else if (consume) begin
            main_vld_d = 1'b0;
          end
        end
        TWO: begin
          // The skid entry always drains into main; it is never bypassed.
          if (consume) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            skid_vld_d  = 1'b0;
          end
        end
        default: begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end
      endcase
    end

    in_ready_d = ~(main_vld_d & skid_vld_d);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q  <= 1'b0;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_vld_q  <= skid_vld_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // NOTE: skid payload needs no reset; it is only ever read while skid_vld_q is set.
  always_ff @(posedge clk) begin
    skid_pc_q   <= skid_pc_d;
    skid_inst_q <= skid_inst_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_pc    = main_pc_q;
  assign out_inst  = main_vld_q ? main_inst_q : NOP_INST;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (!main_vld_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: a FIFO scoreboard of accepted beats checked against the outputs each cycle.
module tb_if_id_skid_reg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [1:0]        occupancy;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0]       bubble_count;
  logic [31:0]       exp_bubbles = '0;
`endif

  beat_t       sb[$];
  logic [63:0] last_pc = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  if_id_skid_reg #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .occupancy (occupancy)
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Outputs are compared to the scoreboard; called #1 after a rising edge.
  task automatic check_state();
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready",  64'(in_ready),  64'(sb.size() != 2));
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("out_pc",    out_pc, last_pc);
    check("out_inst",  64'(out_inst), (sb.size() != 0) ? 64'(sb[0].inst) : 64'(NOP));
`ifdef IF_ID_BUBBLE_CNT_EN
    check("bubble_count", 64'(bubble_count), 64'(exp_bubbles));
`endif
  endtask

  task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    bit    acc, con;
    beat_t b;
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    stall    = st;
    flush    = fl;
    check_state();
    acc = v && (sb.size() < 2);
    con = (sb.size() != 0) && !st;
    if (con && !fl) begin
      check("sb_pc",   out_pc,          sb[0].pc);
      check("sb_inst", 64'(out_inst),   64'(sb[0].inst));
    end
`ifdef IF_ID_BUBBLE_CNT_EN
    if (sb.size() == 0 && exp_bubbles != 32'hFFFF_FFFF) exp_bubbles++;
`endif
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) begin
        b.pc   = pc;
        b.inst = inst;
        sb.push_back(b);
      end
    end
    if (sb.size() != 0) last_pc = sb[0].pc;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 64'hDEAD;
    in_inst  = 32'hBEEF;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    last_pc = '0;
`ifdef IF_ID_BUBBLE_CNT_EN
    exp_bubbles = '0;
`endif
    check_state();
  endtask

  initial begin
    do_reset();

    // Single beat after reset.
    cycle(1'b1, 64'h1000, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Back-to-back stream with no stall.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 64'(4 * i), 32'h00100093 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Stall fills the skid entry, then drains in order.
    cycle(1'b1, 64'h0, 32'h11111111, 1'b0, 1'b0);
    cycle(1'b1, 64'h4, 32'h22222222, 1'b1, 1'b0);
    cycle(1'b1, 64'h8, 32'h33333333, 1'b1, 1'b0);
    cycle(1'b1, 64'h8, 32'h33333333, 1'b1, 1'b0);
    cycle(1'b1, 64'h8, 32'h33333333, 1'b0, 1'b0);
    cycle(1'b1, 64'h8, 32'h33333333, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Flush while full, with a beat offered in the same cycle.
    cycle(1'b1, 64'h10, 32'h44444444, 1'b0, 1'b0);
    cycle(1'b1, 64'h14, 32'h55555555, 1'b1, 1'b0);
    cycle(1'b1, 64'h18, 32'h66666666, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Flush with a beat accepted into an empty buffer is dropped too.
    cycle(1'b1, 64'h1C, 32'h77777777, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Reset mid-stream while full.
    cycle(1'b1, 64'h20, 32'h88888888, 1'b0, 1'b0);
    cycle(1'b1, 64'h24, 32'h99999999, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 64'h2000, 32'h00A00113, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    // Idle then a burst, exercising the bubble counter when it is built in.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h3000 + 64'(4 * i), 32'hA0000000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            {32'($urandom), 32'($urandom)},
            32'($urandom),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
